// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and instruction memory / pipeline.
interface pc_sequencer_if;
  logic       iFetchAck;
  logic       iJumpTaken;
  logic       iBranchTaken;
  logic [9:0] iBranchAddress;
  logic       iHalt;
  logic       iResume;
  logic [9:0] oIP;
  logic       oFetchReq;
  logic       oFlush;
  logic       oHalted;
  logic [2:0] oState;

  // Sequencer side
  modport master (
    input  iFetchAck, iJumpTaken, iBranchTaken, iBranchAddress, iHalt, iResume,
    output oIP, oFetchReq, oFlush, oHalted, oState
  );

  // Memory / control side
  modport slave (
    output iFetchAck, iJumpTaken, iBranchTaken, iBranchAddress, iHalt, iResume,
    input  oIP, oFetchReq, oFlush, oHalted, oState
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-pointer sequencer: fetch handshake, jump/branch redirect with
// pipeline flush, and halt/resume control. All outputs come from flops.
module pc_sequencer #(
  parameter logic [9:0]  RESET_VECTOR = 10'd0,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] ip_q, ip_d;
  logic       pend_q, pend_d;
  logic [9:0] pend_ip_q, pend_ip_d;
  logic       halt_pend_q, halt_pend_d;
  logic [2:0] cnt_q, cnt_d;
  logic       req_q, flush_q, halted_q;

  logic       redirect;
  logic [9:0] offset;
  logic [9:0] branch_tgt;
  logic [9:0] redirect_tgt;
  logic [9:0] ip_inc;
  logic       wait_pend;
  logic [9:0] wait_tgt;
  logic       wait_halt;

  // Redirect target and increment, all wrapping modulo 1024
  always_comb begin
    redirect     = bus.iJumpTaken | bus.iBranchTaken;
    offset       = {5'b0, bus.iBranchAddress[4:0]};
    branch_tgt   = bus.iBranchAddress[5] ? (ip_q - offset) : (ip_q + offset);
    redirect_tgt = bus.iJumpTaken ? bus.iBranchAddress : branch_tgt;
    ip_inc       = ip_q + 10'd1;
    // In WAIT a new redirect overwrites the pending one; any redirect cancels halt
    wait_pend    = redirect | pend_q;
    wait_tgt     = redirect ? redirect_tgt : pend_ip_q;
    wait_halt    = (halt_pend_q | bus.iHalt) & ~wait_pend;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    pend_d      = pend_q;
    pend_ip_d   = pend_ip_q;
    halt_pend_d = halt_pend_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          ip_d        = redirect_tgt;
          state_d     = S_FLUSH;
          cnt_d       = 3'(FLUSH_CYCLES - 1);
          halt_pend_d = 1'b0;
        end else if (bus.iFetchAck) begin
          ip_d    = ip_inc;
          state_d = bus.iHalt ? S_HALT : S_FETCH;
        end else begin
          state_d     = S_WAIT;
          halt_pend_d = bus.iHalt;
        end
      end
      S_WAIT: begin
        if (bus.iFetchAck) begin
          pend_d      = 1'b0;
          halt_pend_d = 1'b0;
          if (wait_pend) begin
            ip_d    = wait_tgt;
            state_d = S_FLUSH;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
          end else begin
            ip_d    = ip_inc;
            state_d = wait_halt ? S_HALT : S_FETCH;
          end
        end else begin
          pend_d      = wait_pend;
          pend_ip_d   = wait_tgt;
          halt_pend_d = wait_halt;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0) state_d = S_FETCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_HALT: if (bus.iResume) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; outputs decoded from next state so they are flops
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ip_q        <= RESET_VECTOR;
      pend_q      <= 1'b0;
      pend_ip_q   <= '0;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      pend_q      <= pend_d;
      pend_ip_q   <= pend_ip_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      req_q       <= (state_d == S_FETCH) || (state_d == S_WAIT);
      flush_q     <= (state_d == S_FLUSH);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign bus.oIP       = ip_q;
  assign bus.oFetchReq = req_q;
  assign bus.oFlush    = flush_q;
  assign bus.oHalted   = halted_q;
  assign bus.oState    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: handshake, redirects, halt and reset.
module tb_pc_sequencer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pc_sequencer_if bus ();
  pc_sequencer_if bus3 ();

  pc_sequencer dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // Second instance with a longer flush, fed the same inputs
  pc_sequencer #(.FLUSH_CYCLES(3)) dut3 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus3)
  );

  assign bus3.iFetchAck      = bus.iFetchAck;
  assign bus3.iJumpTaken     = bus.iJumpTaken;
  assign bus3.iBranchTaken   = bus.iBranchTaken;
  assign bus3.iBranchAddress = bus.iBranchAddress;
  assign bus3.iHalt          = bus.iHalt;
  assign bus3.iResume        = bus.iResume;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iFetchAck      = 1'b0;
    bus.iJumpTaken     = 1'b0;
    bus.iBranchTaken   = 1'b0;
    bus.iBranchAddress = '0;
    bus.iHalt          = 1'b0;
    bus.iResume        = 1'b0;
  endtask

  // Jump to addr and land in FETCH there
  task automatic goto_ip(input logic [9:0] addr);
    bus.iJumpTaken = 1'b1; bus.iBranchAddress = addr;
    step();
    bus.iJumpTaken = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.oState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.oState); end
    checks++; if (bus.oIP !== 10'd0) begin errors++; $display("FAIL reset_ip: got %0d want 0", bus.oIP); end
    checks++; if (bus.oFetchReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", bus.oFetchReq); end
    checks++; if (bus.oFlush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", bus.oFlush); end
    checks++; if (bus.oHalted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", bus.oHalted); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    bus.iFetchAck = 1'b1;
    step();
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd0 || bus.oFetchReq !== 1'b1) begin
      errors++; $display("FAIL seq_first: state=%0d ip=%0d req=%0b want 1/0/1", bus.oState, bus.oIP, bus.oFetchReq); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bus.oIP !== 10'(i)) begin errors++; $display("FAIL seq_inc: got %0d want %0d", bus.oIP, i); end
    end
    goto_ip(10'd1022);
    step();
    checks++; if (bus.oIP !== 10'd1023) begin errors++; $display("FAIL seq_1023: got %0d want 1023", bus.oIP); end
    step();
    checks++; if (bus.oIP !== 10'd0 || bus.oState !== 3'd1) begin
      errors++; $display("FAIL seq_wrap: ip=%0d state=%0d want 0/1", bus.oIP, bus.oState); end
  endtask

  task automatic test_wait_branch();
    goto_ip(10'd10);
    bus.iFetchAck = 1'b0;
    step();
    checks++; if (bus.oState !== 3'd2 || bus.oIP !== 10'd10 || bus.oFetchReq !== 1'b1) begin
      errors++; $display("FAIL wait_enter: state=%0d ip=%0d req=%0b want 2/10/1", bus.oState, bus.oIP, bus.oFetchReq); end
    step();
    bus.iBranchTaken = 1'b1; bus.iBranchAddress = 10'b0000100011;
    step();
    bus.iBranchTaken = 1'b0; bus.iBranchAddress = '0;
    checks++; if (bus.oState !== 3'd2 || bus.oIP !== 10'd10 || bus.oFetchReq !== 1'b1) begin
      errors++; $display("FAIL wait_hold: state=%0d ip=%0d req=%0b want 2/10/1", bus.oState, bus.oIP, bus.oFetchReq); end
    bus.iFetchAck = 1'b1;
    step();
    checks++; if (bus.oState !== 3'd3 || bus.oIP !== 10'd7 || bus.oFlush !== 1'b1 || bus.oFetchReq !== 1'b0) begin
      errors++; $display("FAIL wait_flush: state=%0d ip=%0d flush=%0b req=%0b want 3/7/1/0", bus.oState, bus.oIP, bus.oFlush, bus.oFetchReq); end
    step();
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd7 || bus.oFlush !== 1'b0) begin
      errors++; $display("FAIL wait_refetch: state=%0d ip=%0d flush=%0b want 1/7/0", bus.oState, bus.oIP, bus.oFlush); end
  endtask

  task automatic test_wait_overwrite();
    bus.iFetchAck = 1'b0;
    step();
    bus.iJumpTaken = 1'b1; bus.iBranchAddress = 10'd100;
    step();
    bus.iJumpTaken = 1'b0; bus.iBranchTaken = 1'b1; bus.iBranchAddress = 10'b0000000010;
    step();
    bus.iBranchTaken = 1'b0; bus.iBranchAddress = '0; bus.iFetchAck = 1'b1;
    step();
    checks++; if (bus.oState !== 3'd3 || bus.oIP !== 10'd9) begin
      errors++; $display("FAIL wait_overwrite: state=%0d ip=%0d want 3/9", bus.oState, bus.oIP); end
    step();
  endtask

  task automatic test_branch_wrap();
    goto_ip(10'd1020);
    bus.iFetchAck = 1'b1; bus.iBranchTaken = 1'b1; bus.iBranchAddress = 10'b0000000101;
    step();
    bus.iBranchTaken = 1'b0; bus.iBranchAddress = '0;
    checks++; if (bus.oState !== 3'd3 || bus.oIP !== 10'd1 || bus.oFlush !== 1'b1 || bus.oFetchReq !== 1'b0) begin
      errors++; $display("FAIL fwd_wrap: state=%0d ip=%0d flush=%0b req=%0b want 3/1/1/0", bus.oState, bus.oIP, bus.oFlush, bus.oFetchReq); end
    step();
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd1 || bus.oFlush !== 1'b0) begin
      errors++; $display("FAIL fwd_refetch: state=%0d ip=%0d flush=%0b want 1/1/0", bus.oState, bus.oIP, bus.oFlush); end
    step();
    bus.iFetchAck = 1'b0; bus.iBranchTaken = 1'b1; bus.iBranchAddress = 10'b0000100101;
    step();
    bus.iBranchTaken = 1'b0; bus.iBranchAddress = '0;
    checks++; if (bus.oState !== 3'd3 || bus.oIP !== 10'd1021) begin
      errors++; $display("FAIL back_wrap: state=%0d ip=%0d want 3/1021", bus.oState, bus.oIP); end
    step();
  endtask

  task automatic test_jump_priority();
    bus.iFetchAck = 1'b1; bus.iJumpTaken = 1'b1; bus.iBranchTaken = 1'b1;
    bus.iBranchAddress = 10'd300; bus.iHalt = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.oState !== 3'd3 || bus.oIP !== 10'd300 || bus.oHalted !== 1'b0) begin
      errors++; $display("FAIL jump_prio: state=%0d ip=%0d halted=%0b want 3/300/0", bus.oState, bus.oIP, bus.oHalted); end
    step();
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd300 || bus.oHalted !== 1'b0) begin
      errors++; $display("FAIL jump_nohalt: state=%0d ip=%0d halted=%0b want 1/300/0", bus.oState, bus.oIP, bus.oHalted); end
  endtask

  task automatic test_halt();
    goto_ip(10'd5);
    bus.iFetchAck = 1'b1; bus.iHalt = 1'b1;
    step();
    bus.iFetchAck = 1'b0; bus.iHalt = 1'b0;
    checks++; if (bus.oState !== 3'd4 || bus.oIP !== 10'd6 || bus.oFetchReq !== 1'b0 || bus.oHalted !== 1'b1) begin
      errors++; $display("FAIL halt_enter: state=%0d ip=%0d req=%0b halted=%0b want 4/6/0/1", bus.oState, bus.oIP, bus.oFetchReq, bus.oHalted); end
    bus.iJumpTaken = 1'b1; bus.iBranchAddress = 10'd50;
    step();
    bus.iJumpTaken = 1'b0; bus.iBranchAddress = '0;
    checks++; if (bus.oState !== 3'd4 || bus.oIP !== 10'd6) begin
      errors++; $display("FAIL halt_ignore: state=%0d ip=%0d want 4/6", bus.oState, bus.oIP); end
    bus.iResume = 1'b1;
    step();
    bus.iResume = 1'b0;
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd6 || bus.oFetchReq !== 1'b1 || bus.oHalted !== 1'b0) begin
      errors++; $display("FAIL resume: state=%0d ip=%0d req=%0b halted=%0b want 1/6/1/0", bus.oState, bus.oIP, bus.oFetchReq, bus.oHalted); end
    // Halt requested during an unacked fetch waits for the ack
    bus.iHalt = 1'b1;
    step();
    bus.iHalt = 1'b0;
    step();
    checks++; if (bus.oState !== 3'd2 || bus.oIP !== 10'd6) begin
      errors++; $display("FAIL halt_wait: state=%0d ip=%0d want 2/6", bus.oState, bus.oIP); end
    bus.iFetchAck = 1'b1;
    step();
    bus.iFetchAck = 1'b0;
    checks++; if (bus.oState !== 3'd4 || bus.oIP !== 10'd7) begin
      errors++; $display("FAIL halt_latched: state=%0d ip=%0d want 4/7", bus.oState, bus.oIP); end
    bus.iResume = 1'b1;
    step();
    bus.iResume = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.iFetchAck = 1'b0; bus.iJumpTaken = 1'b1; bus.iBranchAddress = 10'd500;
    step();
    step();
    bus.iJumpTaken = 1'b0; bus.iBranchAddress = '0;
    rst_n = 1'b0;
    step();
    checks++; if (bus.oState !== 3'd0 || bus.oIP !== 10'd0 || bus.oFetchReq !== 1'b0 || bus.oFlush !== 1'b0 || bus.oHalted !== 1'b0) begin
      errors++; $display("FAIL rst_wait: state=%0d ip=%0d req=%0b want 0/0/0", bus.oState, bus.oIP, bus.oFetchReq); end
    rst_n = 1'b1; bus.iFetchAck = 1'b1;
    step();
    step();
    checks++; if (bus.oState !== 3'd1 || bus.oIP !== 10'd1) begin
      errors++; $display("FAIL rst_pend_clear: state=%0d ip=%0d want 1/1", bus.oState, bus.oIP); end
    bus.iJumpTaken = 1'b1; bus.iBranchAddress = 10'd40;
    step();
    bus.iJumpTaken = 1'b0; bus.iBranchAddress = '0;
    rst_n = 1'b0;
    step();
    checks++; if (bus.oState !== 3'd0 || bus.oIP !== 10'd0 || bus.oFlush !== 1'b0 || bus.oFetchReq !== 1'b0) begin
      errors++; $display("FAIL rst_flush: state=%0d ip=%0d flush=%0b want 0/0/0", bus.oState, bus.oIP, bus.oFlush); end
  endtask

  task automatic test_flush_len();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.iFetchAck = 1'b1;
    step();
    bus.iJumpTaken = 1'b1; bus.iBranchAddress = 10'd33;
    step();
    bus.iJumpTaken = 1'b0; bus.iBranchAddress = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus3.oState !== 3'd3 || bus3.oFlush !== 1'b1 || bus3.oFetchReq !== 1'b0) begin
        errors++; $display("FAIL flush3_cyc%0d: state=%0d flush=%0b want 3/1", i, bus3.oState, bus3.oFlush); end
      step();
    end
    checks++; if (bus3.oState !== 3'd1 || bus3.oIP !== 10'd33 || bus3.oFlush !== 1'b0) begin
      errors++; $display("FAIL flush3_end: state=%0d ip=%0d flush=%0b want 1/33/0", bus3.oState, bus3.oIP, bus3.oFlush); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_wait_branch();
    test_wait_overwrite();
    test_branch_wrap();
    test_jump_priority();
    test_halt();
    test_reset_mid();
    test_flush_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
